gpr_write_arbiter: RTL and testbench

// - Shares the single GPR write port (write/inaddr/indata) among NUM_REQ requesters (ALU, load unit, I/O, debug).
// - Round-robin arbitration with per-requester valid/ready handshake; optional locked bursts up to MAX_BURST writes.
// - Registered output stage drives the register file directly; one write per cycle maximum.

---
 rtl/gpr_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_gpr_write_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/gpr_write_arbiter.sv
// Round-robin arbiter sharing the single GPR write port among NUM_REQ requesters,
// with locked bursts and a registered output stage. Define ADDR_CHECK_EN to drop illegal addresses.
module gpr_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int AW        = 4,
    parameter int DW        = 10,
    parameter int NUM_REGS  = 10,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  gpr_hold,
    output logic                  gpr_write,
    output logic [AW-1:0]         gpr_inaddr,
    output logic [DW-1:0]         gpr_indata,
    output logic                  err_addr,
    output logic [2:0]            err_src
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {S_ARB, S_LOCKED} state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_REGS > (1 << AW) || MAX_BURST < 1) begin : g_cfg_chk
        $error("gpr_write_arbiter: illegal parameter combination");
    end

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            gnt_any;
    logic [PW-1:0]   gnt_idx, cand;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            addr_bad;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[PW-1:0];
    endfunction

    // Scan from highest offset down so the nearest valid requester at/after ptr wins.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        req_ready = '0;
        if (!rst && !gpr_hold) begin
            if (state_q == S_ARB) begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    cand = wrap_add(ptr_q, k);
                    if (req_valid[cand]) begin
                        gnt_any = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end else if (req_valid[owner_q]) begin
                gnt_any = 1'b1;
                gnt_idx = owner_q;
            end
        end
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    assign sel_addr = req_addr[gnt_idx*AW +: AW];
    assign sel_data = req_data[gnt_idx*DW +: DW];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (!gpr_hold) begin
            if (state_q == S_ARB) begin
                if (gnt_any) begin
                    ptr_d = wrap_add(gnt_idx, 1);
                    if (req_lock[gnt_idx] && MAX_BURST > 1) begin
                        state_d = S_LOCKED;
                        owner_d = gnt_idx;
                        cnt_d   = BW'(1);
                    end
                end
            end else if (req_valid[owner_q] && req_lock[owner_q]
                         && (int'(cnt_q) + 1 < MAX_BURST)) begin
                cnt_d = cnt_q + BW'(1);
            end else begin
                // Owner dropped valid, dropped lock, or hit the burst limit.
                state_d = S_ARB;
                cnt_d   = '0;
            end
        end
    end

`ifdef ADDR_CHECK_EN
    logic       err_q, err_d;
    logic [2:0] src_q, src_d;
    assign addr_bad = int'(sel_addr) >= NUM_REGS;
    always_comb begin
        err_d = gnt_any && addr_bad;
        src_d = err_d ? 3'(gnt_idx) : src_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            src_q <= '0;
        end else begin
            err_q <= err_d;
            src_q <= src_d;
        end
    end
    assign err_addr = err_q;
    assign err_src  = src_q;
`else
    assign addr_bad = 1'b0;
    assign err_addr = 1'b0;
    assign err_src  = 3'd0;
`endif

    always_comb begin
        wr_d   = gnt_any && !addr_bad;
        addr_d = wr_d ? sel_addr : addr_q;
        data_d = wr_d ? sel_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign gpr_write  = wr_q;
    assign gpr_inaddr = addr_q;
    assign gpr_indata = data_q;
endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed table-driven bench for gpr_write_arbiter (default parameters).
module tb_gpr_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_lock, req_ready;
    logic [15:0] req_addr;
    logic [39:0] req_data;
    logic        gpr_hold, gpr_write, err_addr;
    logic [3:0]  gpr_inaddr;
    logic [9:0]  gpr_indata;
    logic [2:0]  err_src;
    logic [3:0]  addr_a [4];
    logic [9:0]  data_a [4];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_addr[i*4 +: 4]  = addr_a[i];
            req_data[i*10 +: 10] = data_a[i];
        end
    end

    gpr_write_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .gpr_hold(gpr_hold), .gpr_write(gpr_write), .gpr_inaddr(gpr_inaddr),
        .gpr_indata(gpr_indata), .err_addr(err_addr), .err_src(err_src)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] lock;
        logic       hold;
        logic [3:0] rdy;
        logic       wr;
        logic [3:0] addr;
        logic [9:0] data;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic r, input logic [3:0] val, input logic [3:0] lk,
                               input logic h, input logic [3:0] rdy, input logic wr,
                               input logic [3:0] a, input logic [9:0] d);
        vec_t t;
        t.rst = r; t.valid = val; t.lock = lk; t.hold = h;
        t.rdy = rdy; t.wr = wr; t.addr = a; t.data = d;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = 4'(i + 1);
            data_a[i] = 10'h3A0 + 10'(i);
        end
        rst = 1'b1; req_valid = '0; req_lock = '0; gpr_hold = 1'b0;

        //               rst valid    lock     hold rdy     wr  addr   data
        vq.push_back(v(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 4'd0, 10'h000)); // reset
        vq.push_back(v(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 4'd0, 10'h000));
        vq.push_back(v(0, 4'b1111, 4'b0000, 0, 4'b0001, 1, 4'd1, 10'h3A0)); // round robin
        vq.push_back(v(0, 4'b1111, 4'b0000, 0, 4'b0010, 1, 4'd2, 10'h3A1));
        vq.push_back(v(0, 4'b1111, 4'b0000, 0, 4'b0100, 1, 4'd3, 10'h3A2));
        vq.push_back(v(0, 4'b1111, 4'b0000, 0, 4'b1000, 1, 4'd4, 10'h3A3)); // wrap to 0
        vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'd4, 10'h3A3)); // idle holds data
        vq.push_back(v(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 4'd1, 10'h3A0));
        vq.push_back(v(0, 4'b0101, 4'b0100, 0, 4'b0100, 1, 4'd3, 10'h3A2)); // lock burst x4
        vq.push_back(v(0, 4'b0101, 4'b0100, 0, 4'b0100, 1, 4'd3, 10'h3A2));
        vq.push_back(v(0, 4'b0101, 4'b0100, 0, 4'b0100, 1, 4'd3, 10'h3A2));
        vq.push_back(v(0, 4'b0101, 4'b0100, 0, 4'b0100, 1, 4'd3, 10'h3A2));
        vq.push_back(v(0, 4'b0101, 4'b0100, 0, 4'b0001, 1, 4'd1, 10'h3A0)); // burst limit -> req 0
        vq.push_back(v(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 4'd3, 10'h3A2));
        vq.push_back(v(0, 4'b0001, 4'b0100, 0, 4'b0000, 0, 4'd3, 10'h3A2)); // owner drops valid
        vq.push_back(v(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 4'd1, 10'h3A0));
        vq.push_back(v(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 4'd2, 10'h3A1));
        vq.push_back(v(0, 4'b0011, 4'b0000, 0, 4'b0010, 1, 4'd2, 10'h3A1)); // lock dropped
        vq.push_back(v(0, 4'b0011, 4'b0000, 0, 4'b0001, 1, 4'd1, 10'h3A0));
        vq.push_back(v(0, 4'b1000, 4'b0000, 0, 4'b1000, 1, 4'd4, 10'h3A3)); // ptr -> 0
        vq.push_back(v(0, 4'b0101, 4'b0000, 1, 4'b0000, 0, 4'd4, 10'h3A3)); // hold x3
        vq.push_back(v(0, 4'b0101, 4'b0000, 1, 4'b0000, 0, 4'd4, 10'h3A3));
        vq.push_back(v(0, 4'b0101, 4'b0000, 1, 4'b0000, 0, 4'd4, 10'h3A3));
        vq.push_back(v(0, 4'b0101, 4'b0000, 0, 4'b0001, 1, 4'd1, 10'h3A0));
        vq.push_back(v(0, 4'b0101, 4'b0000, 0, 4'b0100, 1, 4'd3, 10'h3A2));
        vq.push_back(v(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 4'd2, 10'h3A1)); // hold inside burst
        vq.push_back(v(0, 4'b0011, 4'b0010, 1, 4'b0000, 0, 4'd2, 10'h3A1));
        vq.push_back(v(0, 4'b0011, 4'b0010, 0, 4'b0010, 1, 4'd2, 10'h3A1));
        vq.push_back(v(0, 4'b0011, 4'b0010, 0, 4'b0010, 1, 4'd2, 10'h3A1));
        vq.push_back(v(0, 4'b0011, 4'b0010, 0, 4'b0010, 1, 4'd2, 10'h3A1));
        vq.push_back(v(0, 4'b0011, 4'b0010, 0, 4'b0001, 1, 4'd1, 10'h3A0));
        vq.push_back(v(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 4'd3, 10'h3A2)); // reset mid-burst
        vq.push_back(v(1, 4'b0101, 4'b0100, 0, 4'b0000, 0, 4'd0, 10'h000));
        vq.push_back(v(0, 4'b0101, 4'b0000, 0, 4'b0001, 1, 4'd1, 10'h3A0));

        foreach (vq[n]) begin
            rst = vq[n].rst; req_valid = vq[n].valid; req_lock = vq[n].lock; gpr_hold = vq[n].hold;
            #1;
            chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(vq[n].rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d gpr_write", n), 32'(gpr_write), 32'(vq[n].wr));
            chk($sformatf("v%0d gpr_inaddr", n), 32'(gpr_inaddr), 32'(vq[n].addr));
            chk($sformatf("v%0d gpr_indata", n), 32'(gpr_indata), 32'(vq[n].data));
            chk($sformatf("v%0d err_addr", n), 32'(err_addr), 32'd0);
        end

        // Illegal address from requester 1 (ptr is 1 here).
        rst = 1'b0; req_valid = 4'b0010; req_lock = '0;
        addr_a[1] = 4'd12; data_a[1] = 10'h3FF;
        #1 chk("bad_addr req_ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
`ifdef ADDR_CHECK_EN
        chk("bad_addr gpr_write", 32'(gpr_write), 32'd0);
        chk("bad_addr err_addr", 32'(err_addr), 32'd1);
        chk("bad_addr err_src", 32'(err_src), 32'd1);
        chk("bad_addr inaddr held", 32'(gpr_inaddr), 32'd1);
`else
        chk("bad_addr gpr_write", 32'(gpr_write), 32'd1);
        chk("bad_addr gpr_inaddr", 32'(gpr_inaddr), 32'd12);
        chk("bad_addr gpr_indata", 32'(gpr_indata), 32'h3FF);
        chk("bad_addr err_addr", 32'(err_addr), 32'd0);
`endif
        addr_a[1] = 4'd9;
        #1 chk("addr9 req_ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        chk("addr9 gpr_write", 32'(gpr_write), 32'd1);
        chk("addr9 gpr_inaddr", 32'(gpr_inaddr), 32'd9);
        chk("addr9 gpr_indata", 32'(gpr_indata), 32'h3FF);
        chk("addr9 err_addr", 32'(err_addr), 32'd0);
`ifdef ADDR_CHECK_EN
        chk("addr9 err_src held", 32'(err_src), 32'd1);
`else
        chk("addr9 err_src", 32'(err_src), 32'd0);
`endif
        req_valid = '0;
        @(posedge clk); #1;
        chk("final idle gpr_write", 32'(gpr_write), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
